shift_arbiter: RTL and testbench

- Sequencer/arbiter that shares the single 32-bit BarrelShift datapath between two requesters: port 0 is the execute-stage ALU shift ops, port 1 is the multi-cycle mul/div helper.
- Round-robin grant; registers operands into the shifter, captures the result and returns it on the owner's response channel with valid/ready.
- Handles out-of-range shift amounts itself so the shifter only ever sees amounts 0..DATA_W-1.

---
 rtl/shift_arb_pkg.sv | 25 ++
 rtl/shift_rr_picker.sv | 25 ++
 rtl/shift_arbiter.sv | 167 ++++++++++++++++
 tb/tb_shift_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared constants for the shift arbiter
//
// Purpose: FSM state encodings, shift direction codes and default widths
//          used by shift_arbiter and its sub-module.
// Ports:   none (package).
// Config:  no macros; the optional arithmetic-shift feature lives in
//          shift_arbiter.sv under SHIFT_ARITH_EN.

package shift_arb_pkg;

    // Sequencer states: one op in flight, IDLE -> EXEC -> RESP -> IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Shift direction as presented on reqN_dir and sh_dir.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Default operand/result width and the fixed width of the shifter's
    // shift-amount input.
    localparam int DEFAULT_DATA_W = 32;
    localparam int SH_AMT_W       = 32;

endpackage

// File: rtl/shift_rr_picker.sv
// rtl/shift_rr_picker.sv - 2-way round-robin picker
//
// Purpose: chooses one of two requesters. A lone valid requester always
//          wins; when both are valid the one not granted last time wins.
// Ports:
//   valid[1:0]  in   request valids, bit N = requester N
//   last        in   id of the requester granted most recently
//   grant[1:0]  out  one-hot grant (all zero when nothing is valid)

module shift_rr_picker (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[0] && valid[1]) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sequencer sharing one barrel shifter
//
// Purpose: shares an external combinational barrel shifter between the
//          execute-stage ALU (requester 0) and the mul/div helper
//          (requester 1). Operands are registered into the shifter, the
//          result is captured and returned on the owner's response channel.
//          Shift amounts >= DATA_W are resolved here so the shifter only
//          ever sees amounts 0..DATA_W-1.
// Config:  define SHIFT_ARITH_EN to add reqN_arith inputs (arithmetic right
//          shift via sign-fill post-masking); undefined = logical only.
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   reqN_valid/reqN_ready         op handshake, N = 0,1
//   reqN_inp/reqN_dir/reqN_amt    operand, direction (0 left, 1 right), amount
//   reqN_arith                    arithmetic right shift (SHIFT_ARITH_EN only)
//   rspN_valid/rspN_ready         result handshake
//   rspN_data                     result, held stable while rspN_valid
//   sh_inp/sh_dir/sh_shiftamt     to the barrel shifter
//   sh_out                        from the barrel shifter (combinational)

module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int AMT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_inp,
    input  logic                req0_dir,
    input  logic [AMT_W-1:0]    req0_amt,
`ifdef SHIFT_ARITH_EN
    input  logic                req0_arith,
`endif
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [DATA_W-1:0]   rsp0_data,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_inp,
    input  logic                req1_dir,
    input  logic [AMT_W-1:0]    req1_amt,
`ifdef SHIFT_ARITH_EN
    input  logic                req1_arith,
`endif
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [DATA_W-1:0]   rsp1_data,

    output logic [DATA_W-1:0]   sh_inp,
    output logic                sh_dir,
    output logic [SH_AMT_W-1:0] sh_shiftamt,
    input  logic [DATA_W-1:0]   sh_out
);

    localparam int                SHW       = $clog2(DATA_W);
    localparam logic [AMT_W-1:0]  AMT_LIMIT = AMT_W'(DATA_W);

    logic [1:0]        state;
    logic              owner;
    logic              last_q;
    logic [SHW-1:0]    amt_q;
    logic              oor_q;
    logic [1:0]        grant;
    logic              sel;
    logic              accept;
    logic [DATA_W-1:0] sel_inp;
    logic              sel_dir;
    logic [AMT_W-1:0]  sel_amt;
    logic              sel_oor;
    logic [DATA_W-1:0] result;
`ifdef SHIFT_ARITH_EN
    logic              sel_arith;
    logic              arith_q;
`endif

    shift_rr_picker u_picker (
        .valid ({req1_valid, req0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    // Ready is also gated by rst so it reads 0 while reset is held even
    // though the state register already sits in IDLE.
    assign req0_ready = rst && (state == ST_IDLE) && grant[0];
    assign req1_ready = rst && (state == ST_IDLE) && grant[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp0_valid = (state == ST_RESP) && !owner;
    assign rsp1_valid = (state == ST_RESP) &&  owner;

    assign sel     = grant[1];
    assign sel_inp = sel ? req1_inp : req0_inp;
    assign sel_dir = sel ? req1_dir : req0_dir;
    assign sel_amt = sel ? req1_amt : req0_amt;
    assign sel_oor = (sel_amt >= AMT_LIMIT);
`ifdef SHIFT_ARITH_EN
    assign sel_arith = sel ? req1_arith : req0_arith;
`endif

    // amt_q is already forced to 0 for out-of-range amounts.
    assign sh_shiftamt = {{(SH_AMT_W-SHW){1'b0}}, amt_q};

    always_comb begin
        result = oor_q ? '0 : sh_out;
`ifdef SHIFT_ARITH_EN
        // Negative operand on an arithmetic right shift: OR in the top amt
        // bits to sign-fill the logical result; out-of-range gives all-ones.
        if (arith_q && sh_inp[DATA_W-1]) begin
            result = oor_q ? '1 : (sh_out | ~({DATA_W{1'b1}} >> amt_q));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            last_q    <= 1'b1;
            sh_inp    <= '0;
            sh_dir    <= DIR_LEFT;
            amt_q     <= '0;
            oor_q     <= 1'b0;
            rsp0_data <= '0;
            rsp1_data <= '0;
`ifdef SHIFT_ARITH_EN
            arith_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner  <= sel;
                        last_q <= sel;
                        sh_inp <= sel_inp;
                        sh_dir <= sel_dir;
                        oor_q  <= sel_oor;
                        amt_q  <= sel_oor ? '0 : sel_amt[SHW-1:0];
`ifdef SHIFT_ARITH_EN
                        arith_q <= sel_arith && (sel_dir == DIR_RIGHT);
`endif
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (owner) begin
                        rsp1_data <= result;
                    end else begin
                        rsp0_data <= result;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner ? rsp1_ready : rsp0_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter

module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_dir, rsp0_valid, rsp0_ready;
    logic [31:0] req0_inp, req0_amt, rsp0_data;
    logic        req1_valid, req1_ready, req1_dir, rsp1_valid, rsp1_ready;
    logic [31:0] req1_inp, req1_amt, rsp1_data;
`ifdef SHIFT_ARITH_EN
    logic        req0_arith, req1_arith;
`endif
    logic [31:0] sh_inp, sh_shiftamt, sh_out;
    logic        sh_dir;
    logic        sh_amt_bad = 1'b0;

    int checks = 0;
    int errors = 0;

    shift_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_inp    (req0_inp),
        .req0_dir    (req0_dir),
        .req0_amt    (req0_amt),
`ifdef SHIFT_ARITH_EN
        .req0_arith  (req0_arith),
`endif
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_data   (rsp0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_inp    (req1_inp),
        .req1_dir    (req1_dir),
        .req1_amt    (req1_amt),
`ifdef SHIFT_ARITH_EN
        .req1_arith  (req1_arith),
`endif
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_data   (rsp1_data),
        .sh_inp      (sh_inp),
        .sh_dir      (sh_dir),
        .sh_shiftamt (sh_shiftamt),
        .sh_out      (sh_out)
    );

    always #5 clk = ~clk;

    // Behavioural barrel shifter.
    assign sh_out = sh_dir ? (sh_inp >> sh_shiftamt) : (sh_inp << sh_shiftamt);

    always @(negedge clk) begin
        if (sh_shiftamt >= 32) sh_amt_bad <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Reference: SV shifts by a full 32-bit amount already give 0 (or the
    // sign fill for >>>) once the amount reaches the width.
    function automatic logic [31:0] ref_shift(input logic [31:0] inp, input logic dir,
                                              input logic [31:0] amt, input logic arith);
        if (!dir) return inp << amt;
        if (arith) return $signed(inp) >>> amt;
        return inp >> amt;
    endfunction

    function automatic logic rdy(input int p);
        return (p != 0) ? req1_ready : req0_ready;
    endfunction
    function automatic logic rspv(input int p);
        return (p != 0) ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic [31:0] rspd(input int p);
        return (p != 0) ? rsp1_data : rsp0_data;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] inp,
                           input logic dir, input logic [31:0] amt, input logic arith);
        if (p == 0) begin
            req0_valid = v; req0_inp = inp; req0_dir = dir; req0_amt = amt;
`ifdef SHIFT_ARITH_EN
            req0_arith = arith;
`endif
        end else begin
            req1_valid = v; req1_inp = inp; req1_dir = dir; req1_amt = amt;
`ifdef SHIFT_ARITH_EN
            req1_arith = arith;
`endif
        end
        if (arith && 1'b0) $display("unused");
    endtask

    task automatic set_rr(input int p, input logic v);
        if (p == 0) rsp0_ready = v; else rsp1_ready = v;
    endtask

    // Issue one op on port p from IDLE, check latency, routing, data hold
    // for 'hold' cycles (other port blocked meanwhile) and the handshake.
    task automatic run_op(input int p, input logic [31:0] inp, input logic dir,
                          input logic [31:0] amt, input logic arith, input int hold,
                          input string tag);
        logic [31:0] exp;
        int waited;
        exp = ref_shift(inp, dir, amt, arith);
        waited = 0;
        set_req(p, 1'b1, inp, dir, amt, arith);
        #1;
        while (!rdy(p) && waited < 10) begin
            tick();
            waited++;
        end
        chk({tag, "_ready"}, {31'd0, rdy(p)}, 32'd1);
        chk({tag, "_ready_wait"}, waited, 32'd0);
        if (!rdy(p)) begin
            set_req(p, 1'b0, inp, dir, amt, arith);
            return;
        end
        tick();
        set_req(p, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk({tag, "_exec_novalid"}, {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, rspv(p)}, 32'd1);
        chk({tag, "_data"}, rspd(p), exp);
        chk({tag, "_other_valid"}, {31'd0, rspv(1 - p)}, 32'd0);
        if (hold > 0) set_req(1 - p, 1'b1, 32'h1234_5678, 1'b0, 32'd1, 1'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, {31'd0, rspv(p)}, 32'd1);
            chk({tag, "_hold_data"}, rspd(p), exp);
            chk({tag, "_hold_other_ready"}, {31'd0, rdy(1 - p)}, 32'd0);
            chk({tag, "_hold_other_valid"}, {31'd0, rspv(1 - p)}, 32'd0);
        end
        set_req(1 - p, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        set_rr(p, 1'b1);
        tick();
        set_rr(p, 1'b0);
        chk({tag, "_done"}, {31'd0, rspv(p)}, 32'd0);
    endtask

    logic [31:0] cur_inp [2];
    logic        cur_dir [2];
    logic [31:0] cur_amt [2];
    logic        cur_ari [2];

    initial begin
        int o;
        int p;
        logic [31:0] exp;
        logic [31:0] amt;
        logic        ari;

        rst = 1'b0;
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Reset state, with a requester already waiting.
        tick();
        req0_valid = 1'b1;
        #1;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp0_data", rsp0_data, 32'd0);
        chk("rst_rsp1_data", rsp1_data, 32'd0);
        chk("rst_sh_inp", sh_inp, 32'd0);
        chk("rst_sh_dir", {31'd0, sh_dir}, 32'd0);
        chk("rst_sh_amt", sh_shiftamt, 32'd0);
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Directed ops.
        run_op(0, 32'h0F0F_0F0F, 1'b1, 32'd13, 1'b0, 0, "r13");
        run_op(1, 32'h0F0F_0F0F, 1'b0, 32'd4, 1'b0, 5, "l4_hold");
        run_op(0, 32'h0F0F_0F0F, 1'b1, 32'd34, 1'b0, 0, "r34");
        run_op(0, 32'h0F0F_0F0F, 1'b1, 32'd0, 1'b0, 0, "r0");
        run_op(1, 32'hDEAD_BEEF, 1'b0, 32'd32, 1'b0, 1, "l32");
        run_op(1, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_FFFF, 1'b0, 0, "lmax");
        run_op(0, 32'h8000_0001, 1'b1, 32'd31, 1'b0, 0, "r31");
        chk("const_expect_r13", ref_shift(32'h0F0F_0F0F, 1'b1, 32'd13, 1'b0), 32'h0000_7878);

        // Both valid continuously from reset: grants alternate 0,1,0,1.
        rst = 1'b0;
        for (int q = 0; q < 2; q++) begin
            cur_inp[q] = $urandom; cur_dir[q] = 1'($urandom_range(0, 1));
            cur_amt[q] = $urandom_range(0, 40); cur_ari[q] = 1'b0;
            set_req(q, 1'b1, cur_inp[q], cur_dir[q], cur_amt[q], cur_ari[q]);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            o = k % 2;
            exp = ref_shift(cur_inp[o], cur_dir[o], cur_amt[o], cur_ari[o]);
            #1;
            chk("alt_ready_owner", {31'd0, rdy(o)}, 32'd1);
            chk("alt_ready_other", {31'd0, rdy(1 - o)}, 32'd0);
            tick();
            cur_inp[o] = $urandom; cur_dir[o] = 1'($urandom_range(0, 1));
            cur_amt[o] = $urandom_range(0, 40);
            set_req(o, 1'b1, cur_inp[o], cur_dir[o], cur_amt[o], cur_ari[o]);
            tick();
            chk("alt_rsp_valid", {31'd0, rspv(o)}, 32'd1);
            chk("alt_rsp_data", rspd(o), exp);
            chk("alt_other_valid", {31'd0, rspv(1 - o)}, 32'd0);
            set_rr(o, 1'b1);
            tick();
            set_rr(o, 1'b0);
        end
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Reset during EXEC drops the op.
        set_req(0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'd3, 1'b0);
        #1;
        chk("mid_accept", {31'd0, req0_ready}, 32'd1);
        tick();
        set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("mid_rst_sh_inp", sh_inp, 32'd0);
        tick();
        rst = 1'b1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        rsp0_ready = 1'b0;
        run_op(1, 32'h1357_9BDF, 1'b1, 32'd8, 1'b0, 0, "post_rst");

`ifdef SHIFT_ARITH_EN
        run_op(0, 32'h8000_0000, 1'b1, 32'd4, 1'b1, 0, "ar4");
        run_op(0, 32'h8000_0000, 1'b1, 32'd40, 1'b1, 0, "ar40");
        run_op(1, 32'h7000_0000, 1'b1, 32'd40, 1'b1, 0, "ar40pos");
        run_op(1, 32'h8000_0000, 1'b0, 32'd4, 1'b1, 0, "arleft");
        chk("const_expect_ar4", ref_shift(32'h8000_0000, 1'b1, 32'd4, 1'b1), 32'hF800_0000);
`endif

        // Randomized ops against the reference model.
        for (int k = 0; k < 24; k++) begin
            p = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       amt = $urandom;
                1:       amt = $urandom_range(32, 70);
                default: amt = $urandom_range(0, 31);
            endcase
`ifdef SHIFT_ARITH_EN
            ari = 1'($urandom_range(0, 1));
`else
            ari = 1'b0;
`endif
            run_op(p, $urandom, 1'($urandom_range(0, 1)), amt, ari,
                   int'($urandom_range(0, 2)), "rand");
        end

        chk("sh_amt_in_range", {31'd0, sh_amt_bad}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
